// File: rtl/pe_array_sequencer.sv
// Configuration and run sequencer for a row of processing elements: loads one
// control word per PE into shadow registers, then enables the row for a counted run.
module pe_array_sequencer #(
  parameter int NUM_PE = 4,
  parameter int CTRL_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       skip_load,
  input  logic [CNT_W-1:0]           run_len,
  input  logic                       cfg_valid,
  input  logic [CTRL_W-1:0]          cfg_data,
  output logic                       cfg_ready,
  input  logic                       hold,
  input  logic                       abort,
  output logic [NUM_PE*CTRL_W-1:0]   ctrl_out,
  output logic [NUM_PE-1:0]          pe_en,
  output logic                       busy,
  output logic                       done,
  output logic [1:0]                 state_o
);

  localparam int IDX_W = $clog2(NUM_PE);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PE - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t                         state_r;
  logic [IDX_W-1:0]               idx_r;
  logic [CNT_W-1:0]               cnt_r;
  logic [CNT_W-1:0]               len_r;
  logic [NUM_PE-1:0][CTRL_W-1:0]  word_r;

  // Sequencer state, shadow words and run counter
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
      idx_r   <= '0;
      cnt_r   <= '0;
      len_r   <= '0;
      word_r  <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            len_r <= run_len;
            idx_r <= '0;
            cnt_r <= '0;
            if (skip_load) begin
              state_r <= (run_len == '0) ? ST_DONE : ST_RUN;
            end else begin
              state_r <= ST_LOAD;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_LOAD: begin
          if (abort) begin
            state_r <= ST_IDLE;
            idx_r   <= '0;
            cnt_r   <= '0;
          end else if (cfg_valid) begin
            word_r[idx_r] <= cfg_data;
            if (idx_r == LAST_IDX) begin
              idx_r   <= '0;
              state_r <= (len_r == '0) ? ST_DONE : ST_RUN;
            end else begin
              idx_r <= idx_r + IDX_W'(1);
            end
          end else begin
            state_r <= ST_LOAD;
          end
        end
        ST_RUN: begin
          if (abort) begin
            state_r <= ST_IDLE;
            idx_r   <= '0;
            cnt_r   <= '0;
          end else if (!hold) begin
            // len_r is never zero here: a zero length bypasses RUN entirely
            if (cnt_r == len_r - CNT_W'(1)) begin
              cnt_r   <= '0;
              state_r <= ST_DONE;
            end else begin
              cnt_r <= cnt_r + CNT_W'(1);
            end
          end else begin
            state_r <= ST_RUN;
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
          idx_r   <= '0;
          cnt_r   <= '0;
        end
        default: begin
          state_r <= ST_IDLE;
          idx_r   <= '0;
          cnt_r   <= '0;
        end
      endcase
    end
  end

  // Output decode from state plus hold/abort so that abort and reset act without a clock edge
  always_comb begin
    pe_en     = '0;
    cfg_ready = 1'b0;
    done      = 1'b0;
    busy      = (state_r != ST_IDLE);
    state_o   = state_r;
    case (state_r)
      ST_IDLE: begin
        pe_en = '0;
      end
      ST_LOAD: begin
        cfg_ready = !abort;
      end
      ST_RUN: begin
        if (!hold && !abort) begin
          pe_en = '1;
        end else begin
          pe_en = '0;
        end
      end
      ST_DONE: begin
        done = !abort;
      end
      default: begin
        pe_en = '0;
      end
    endcase
  end

  assign ctrl_out = word_r;

endmodule

// File: tb/tb_pe_array_sequencer.sv
// Self-checking bench for pe_array_sequencer: directed scenarios plus randomized
// sequences compared against a sequence-level reference model.
module tb_pe_array_sequencer;

  logic        clock;
  logic        reset;
  logic        start;
  logic        skip_load;
  logic [7:0]  run_len;
  logic        cfg_valid;
  logic [7:0]  cfg_data;
  logic        cfg_ready;
  logic        hold;
  logic        abort;
  logic [31:0] ctrl_out;
  logic [3:0]  pe_en;
  logic        busy;
  logic        done;
  logic [1:0]  state_o;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] model_ctrl = 32'h0;

  pe_array_sequencer #(.NUM_PE(4), .CTRL_W(8), .CNT_W(8)) dut (
    .clock(clock), .reset(reset), .start(start), .skip_load(skip_load),
    .run_len(run_len), .cfg_valid(cfg_valid), .cfg_data(cfg_data),
    .cfg_ready(cfg_ready), .hold(hold), .abort(abort), .ctrl_out(ctrl_out),
    .pe_en(pe_en), .busy(busy), .done(done), .state_o(state_o)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Issue a start pulse; on return the sequencer is in its first post-IDLE cycle
  task automatic start_seq(input bit skip, input logic [7:0] len);
    start = 1'b1; skip_load = skip; run_len = len;
    @(posedge clock); #1;
    start = 1'b0; skip_load = 1'b0; run_len = 8'($urandom);
  endtask

  // Feed nwords config words (gap_mode 0 none, 1 every word, 2 random); updates the model
  task automatic load_seq(input logic [31:0] words, input int nwords, input int gap_mode,
                          output bit ready_ok);
    ready_ok = 1'b1;
    for (int i = 0; i < nwords; i++) begin
      if (gap_mode == 1 || (gap_mode == 2 && $urandom_range(0, 1) == 1)) begin
        cfg_valid = 1'b0; cfg_data = 8'($urandom);
        @(negedge clock);
        if (cfg_ready !== 1'b1) ready_ok = 1'b0;
        @(posedge clock); #1;
      end
      cfg_valid = 1'b1; cfg_data = words[8*i +: 8];
      @(negedge clock);
      if (cfg_ready !== 1'b1) ready_ok = 1'b0;
      @(posedge clock); #1;
      model_ctrl[8*i +: 8] = words[8*i +: 8];
    end
    cfg_valid = 1'b0;
  endtask

  // Watch one RUN/DONE phase until IDLE, applying hold_len hold cycles once hold_after cycles were enabled
  task automatic observe(input int hold_after, input int hold_len, input bit poke_start,
                         output int run_cyc, output int en_cyc, output int done_cnt,
                         output int done_at, output int last_en_at, output bit ready_seen,
                         output bit ctrl_moved, output bit en_bad, output bit timed_out);
    logic [31:0] ctrl0;
    int applied;
    bit stop;
    run_cyc = 0; en_cyc = 0; done_cnt = 0; done_at = -1; last_en_at = -1;
    ready_seen = 1'b0; ctrl_moved = 1'b0; en_bad = 1'b0; applied = 0; stop = 1'b0;
    ctrl0 = ctrl_out;
    for (int cyc = 0; cyc < 200; cyc++) begin
      if (state_o == 2'd2 && en_cyc >= hold_after && applied < hold_len) begin
        hold = 1'b1; applied++;
      end else begin
        hold = 1'b0;
      end
      start = poke_start && (state_o == 2'd3);
      run_len = 8'($urandom);
      @(negedge clock);
      if (state_o == 2'd2) run_cyc++;
      if (pe_en == 4'hF) begin
        en_cyc++; last_en_at = cyc;
      end else if (pe_en != 4'h0) begin
        en_bad = 1'b1;
      end
      if (done) begin
        done_cnt++; done_at = cyc;
      end
      if (cfg_ready) ready_seen = 1'b1;
      if (ctrl_out != ctrl0) ctrl_moved = 1'b1;
      if (state_o == 2'd0) stop = 1'b1;
      @(posedge clock); #1;
      if (stop) break;
    end
    hold = 1'b0; start = 1'b0;
    timed_out = !stop;
  endtask

  task automatic test_reset();
    bit rdy;
    @(negedge clock);
    n_checks++;
    if ({state_o, busy, done, cfg_ready, pe_en, ctrl_out} !== 40'h0) $display("FAIL reset_idle: got state=%0d busy=%b done=%b rdy=%b en=%h ctrl=%h, want all 0", state_o, busy, done, cfg_ready, pe_en, ctrl_out);
    else n_pass++;
    @(posedge clock); #1;
    start_seq(1'b0, 8'd50);
    load_seq(32'h5A6B7C8D, 4, 0, rdy);
    @(posedge clock); @(posedge clock); #3;
    n_checks++;
    if (pe_en !== 4'hF) $display("FAIL reset_prerun_en: got %h want f", pe_en);
    else n_pass++;
    reset = 1'b0;
    #1;
    n_checks++;
    if (pe_en !== 4'h0) $display("FAIL reset_async_en: got %h want 0", pe_en);
    else n_pass++;
    @(negedge clock);
    reset = 1'b1;
    n_checks++;
    if (state_o !== 2'd0 || ctrl_out !== 32'h0 || cfg_ready !== 1'b0 || busy !== 1'b0)
      $display("FAIL reset_after: got state=%0d ctrl=%h rdy=%b busy=%b want 0/0/0/0", state_o, ctrl_out, cfg_ready, busy);
    else n_pass++;
    model_ctrl = 32'h0;
    @(posedge clock); #1;
  endtask

  task automatic test_full_load();
    bit rdy, rs, cm, eb, to;
    int rc, ec, dc, da, le;
    start_seq(1'b0, 8'd3);
    load_seq(32'h44332211, 4, 1, rdy);
    n_checks++;
    if (rdy !== 1'b1) $display("FAIL full_cfg_ready: cfg_ready low during LOAD, want high");
    else n_pass++;
    n_checks++;
    if (ctrl_out !== 32'h44332211) $display("FAIL full_ctrl: got %h want 44332211", ctrl_out);
    else n_pass++;
    observe(99, 0, 1'b1, rc, ec, dc, da, le, rs, cm, eb, to);
    n_checks++;
    if (to || ec != 3 || rc != 3 || eb) $display("FAIL full_run: got en=%0d run=%0d bad=%b timeout=%b want 3/3/0/0", ec, rc, eb, to);
    else n_pass++;
    n_checks++;
    if (dc != 1 || da != le + 1) $display("FAIL full_done: got pulses=%0d at=%0d want 1 at %0d", dc, da, le + 1);
    else n_pass++;
    repeat (2) @(posedge clock);
    @(negedge clock);
    n_checks++;
    if (state_o !== 2'd0 || busy !== 1'b0) $display("FAIL full_idle_after_done_start: got state=%0d want 0", state_o);
    else n_pass++;
    @(posedge clock); #1;
  endtask

  task automatic test_hold();
    bit rs, cm, eb, to;
    int rc, ec, dc, da, le;
    start_seq(1'b1, 8'd5);
    observe(2, 2, 1'b0, rc, ec, dc, da, le, rs, cm, eb, to);
    n_checks++;
    if (to || rc != 7 || ec != 5) $display("FAIL hold_run: got run=%0d en=%0d timeout=%b want 7/5/0", rc, ec, to);
    else n_pass++;
    n_checks++;
    if (dc != 1 || da != le + 1) $display("FAIL hold_done: got pulses=%0d at=%0d want 1 at %0d", dc, da, le + 1);
    else n_pass++;
  endtask

  task automatic test_skip_load();
    bit rs, cm, eb, to;
    int rc, ec, dc, da, le;
    start_seq(1'b1, 8'd2);
    observe(99, 0, 1'b0, rc, ec, dc, da, le, rs, cm, eb, to);
    n_checks++;
    if (to || rs || ec != 2 || dc != 1) $display("FAIL skip_run: got rdy_seen=%b en=%0d done=%0d timeout=%b want 0/2/1/0", rs, ec, dc, to);
    else n_pass++;
    n_checks++;
    if (ctrl_out !== 32'h44332211 || cm) $display("FAIL skip_ctrl: got %h moved=%b want 44332211", ctrl_out, cm);
    else n_pass++;
  endtask

  task automatic test_zero_len();
    bit rdy, rs, cm, eb, to;
    int rc, ec, dc, da, le;
    start_seq(1'b0, 8'd0);
    load_seq(32'h44332211, 4, 0, rdy);
    n_checks++;
    if (state_o !== 2'd3) $display("FAIL zero_state: got %0d want 3 after last word", state_o);
    else n_pass++;
    observe(99, 0, 1'b0, rc, ec, dc, da, le, rs, cm, eb, to);
    n_checks++;
    if (to || ec != 0 || rc != 0 || dc != 1) $display("FAIL zero_run: got en=%0d run=%0d done=%0d timeout=%b want 0/0/1/0", ec, rc, dc, to);
    else n_pass++;
  endtask

  task automatic test_abort_load();
    bit rdy;
    int dc;
    start_seq(1'b0, 8'd3);
    load_seq(32'h0000BBAA, 2, 0, rdy);
    abort = 1'b1; start = 1'b1; cfg_valid = 1'b1; cfg_data = 8'hCC;
    @(negedge clock);
    n_checks++;
    if (cfg_ready !== 1'b0 || pe_en !== 4'h0 || done !== 1'b0) $display("FAIL abort_same_cycle: got rdy=%b en=%h done=%b want 0/0/0", cfg_ready, pe_en, done);
    else n_pass++;
    @(posedge clock); #1;
    abort = 1'b0; start = 1'b0; cfg_valid = 1'b0;
    dc = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      if (done || state_o != 2'd0) dc++;
      @(posedge clock); #1;
    end
    n_checks++;
    if (dc != 0) $display("FAIL abort_idle: got %0d non-idle/done cycles want 0", dc);
    else n_pass++;
    n_checks++;
    if (ctrl_out !== 32'h4433BBAA) $display("FAIL abort_ctrl: got %h want 4433bbaa", ctrl_out);
    else n_pass++;
  endtask

  task automatic test_random();
    bit rdy, rs, cm, eb, to, skip;
    int rc, ec, dc, da, le, len, ha, hl, cut;
    logic [31:0] words;
    for (int it = 0; it < 25; it++) begin
      skip = ($urandom_range(0, 3) == 0);
      len = $urandom_range(0, 6);
      words = $urandom;
      cut = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 3) : 4;
      start_seq(skip, 8'(len));
      if (!skip) begin
        load_seq(words, cut, 2, rdy);
        if (cut < 4) begin
          abort = 1'b1;
          @(posedge clock); #1;
          abort = 1'b0;
          @(negedge clock);
          n_checks++;
          if (state_o !== 2'd0 || ctrl_out !== model_ctrl) $display("FAIL rand_abort it%0d: got state=%0d ctrl=%h want 0/%h", it, state_o, ctrl_out, model_ctrl);
          else n_pass++;
          @(posedge clock); #1;
          continue;
        end
      end
      ha = (len > 0) ? $urandom_range(0, len - 1) : 0;
      hl = $urandom_range(0, 3);
      observe(ha, hl, 1'b1, rc, ec, dc, da, le, rs, cm, eb, to);
      n_checks++;
      if (to || ec != len || rc != ((len == 0) ? 0 : len + hl) || dc != 1 || eb)
        $display("FAIL rand_run it%0d: got en=%0d run=%0d done=%0d bad=%b timeout=%b want %0d/%0d/1/0/0", it, ec, rc, dc, eb, to, len, (len == 0) ? 0 : len + hl);
      else n_pass++;
      n_checks++;
      if (ctrl_out !== model_ctrl) $display("FAIL rand_ctrl it%0d: got %h want %h", it, ctrl_out, model_ctrl);
      else n_pass++;
    end
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; skip_load = 1'b0; run_len = 8'd0;
    cfg_valid = 1'b0; cfg_data = 8'd0; hold = 1'b0; abort = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock); #1;
    test_reset();
    test_full_load();
    test_hold();
    test_skip_load();
    test_zero_len();
    test_abort_load();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
